contador_param: RTL and testbench

//   Parametrised up/down counter: the next generation of the fixed counter under tt_um_contador.

---
 rtl/contador_param_if.sv | 28 ++
 rtl/contador_param.sv | 96 +++++++++
 tb/tb_contador_param.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_param_if.sv
// Control/status bundle between the tt_um_contador wrapper and the
// parametrised counter.
interface contador_param_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  dir;
  logic                  mode_sat;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      max_val;
  logic [PRESCALE_W-1:0] presc;
  logic [WIDTH-1:0]      cmp_val;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  cmp_match;

  modport master (
    output en, dir, mode_sat, load, load_val, max_val, presc, cmp_val,
    input  count, tc, cmp_match
  );

  modport slave (
    input  en, dir, mode_sat, load, load_val, max_val, presc, cmp_val,
    output count, tc, cmp_match
  );
endinterface

// File: rtl/contador_param.sv
// Up/down counter with runtime modulo, wrap/saturate mode, synchronous load,
// programmable prescaler, terminal-count pulse and compare-match flag.
module contador_param #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  contador_param_if.slave  bus
);
  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      count_r;
  logic                  tc_r;
  logic [PRESCALE_W-1:0] pre_cnt_r;
  logic [WIDTH-1:0]      cnt_nxt_s;
  logic                  tc_nxt_s;
  logic [PRESCALE_W-1:0] pre_nxt_s;
  logic                  tick_s;

  assign tick_s        = bus.en && (pre_cnt_r == bus.presc);
  assign bus.count     = count_r;
  assign bus.tc        = tc_r;
  assign bus.cmp_match = (count_r == bus.cmp_val);

  // Prescaler next state: load restarts the divide period.
  always_comb begin
    pre_nxt_s = pre_cnt_r;
    if (bus.load) begin
      pre_nxt_s = PRE_ZERO;
    end else if (tick_s) begin
      pre_nxt_s = PRE_ZERO;
    end else if (bus.en) begin
      pre_nxt_s = pre_cnt_r + PRE_ONE;
    end else begin
      pre_nxt_s = pre_cnt_r;
    end
  end

  // Counter next state; tc marks a wrap, or arrival at the limit in saturate mode.
  always_comb begin
    cnt_nxt_s = count_r;
    tc_nxt_s  = 1'b0;
    if (bus.load) begin
      cnt_nxt_s = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      tc_nxt_s  = 1'b0;
    end else if (tick_s) begin
      if (bus.dir) begin
        if (count_r < bus.max_val) begin
          cnt_nxt_s = count_r + CNT_ONE;
          tc_nxt_s  = bus.mode_sat && ((count_r + CNT_ONE) == bus.max_val);
        end else if (bus.mode_sat) begin
          cnt_nxt_s = bus.max_val;
          tc_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = CNT_ZERO;
          tc_nxt_s  = 1'b1;
        end
      end else begin
        // A lowered max_val pulls an out-of-range count back to the limit first.
        if (count_r > bus.max_val) begin
          cnt_nxt_s = bus.max_val;
          tc_nxt_s  = 1'b0;
        end else if (count_r != CNT_ZERO) begin
          cnt_nxt_s = count_r - CNT_ONE;
          tc_nxt_s  = bus.mode_sat && (count_r == CNT_ONE);
        end else if (bus.mode_sat) begin
          cnt_nxt_s = CNT_ZERO;
          tc_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = bus.max_val;
          tc_nxt_s  = 1'b1;
        end
      end
    end else begin
      cnt_nxt_s = count_r;
      tc_nxt_s  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= CNT_ZERO;
      tc_r      <= 1'b0;
      pre_cnt_r <= PRE_ZERO;
    end else begin
      count_r   <= cnt_nxt_s;
      tc_r      <= tc_nxt_s;
      pre_cnt_r <= pre_nxt_s;
    end
  end
endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench for contador_param: directed scenarios followed by random
// traffic, checked against an integer reference model.
module tb_contador_param;
  localparam int WIDTH = 8;
  localparam int PW    = 4;

  typedef struct {
    int cnt;
    bit tc;
    bit cmp;
  } exp_t;

  logic clk;
  logic rst;
  contador_param_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

  contador_param #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  int s_en, s_dir, s_sat, s_load, s_lv, s_max, s_presc, s_cmp;
  int m_cnt, m_pre;
  bit m_tc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one registered result per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.count !== WIDTH'(e.cnt) || bus.tc !== e.tc || bus.cmp_match !== e.cmp) begin
          failed++;
          $display("FAIL scoreboard t=%0t got count=%0d tc=%0b cmp=%0b expected count=%0d tc=%0b cmp=%0b",
                   $time, bus.count, bus.tc, bus.cmp_match, e.cnt, e.tc, e.cmp);
        end
      end
    end
  end

  // Apply current stimulus, advance the reference model, queue the expectation.
  task automatic drive_cycle();
    exp_t e;
    bit   tick;
    bus.en       = 1'(s_en);
    bus.dir      = 1'(s_dir);
    bus.mode_sat = 1'(s_sat);
    bus.load     = 1'(s_load);
    bus.load_val = WIDTH'(s_lv);
    bus.max_val  = WIDTH'(s_max);
    bus.presc    = PW'(s_presc);
    bus.cmp_val  = WIDTH'(s_cmp);
    tick = (s_en != 0) && (m_pre == s_presc);
    if (s_load != 0) begin
      m_cnt = (s_lv > s_max) ? s_max : s_lv;
      m_tc  = 1'b0;
      m_pre = 0;
    end else begin
      m_tc = 1'b0;
      if (tick) begin
        if (s_dir != 0) begin
          if (m_cnt < s_max) begin
            m_cnt = m_cnt + 1;
            m_tc  = (s_sat != 0) && (m_cnt == s_max);
          end else if (s_sat != 0) begin
            m_cnt = s_max;
          end else begin
            m_cnt = 0;
            m_tc  = 1'b1;
          end
        end else begin
          if (m_cnt > s_max) begin
            m_cnt = s_max;
          end else if (m_cnt > 0) begin
            m_tc  = (s_sat != 0) && (m_cnt == 1);
            m_cnt = m_cnt - 1;
          end else if (s_sat == 0) begin
            m_cnt = s_max;
            m_tc  = 1'b1;
          end
        end
      end
      if (s_en != 0) m_pre = tick ? 0 : (m_pre + 1) % (1 << PW);
    end
    e.cnt = m_cnt;
    e.tc  = m_tc;
    e.cmp = (m_cnt == s_cmp);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  task automatic check_now(input string name, input int ec, input bit etc, input bit ecm);
    @(posedge clk);
    #2;
    tests++;
    if (bus.count !== WIDTH'(ec) || bus.tc !== etc || bus.cmp_match !== ecm) begin
      failed++;
      $display("FAIL %s got count=%0d tc=%0b cmp=%0b expected count=%0d tc=%0b cmp=%0b",
               name, bus.count, bus.tc, bus.cmp_match, ec, etc, ecm);
    end
  endtask

  // Raise rst between edges and check the outputs clear without a clock.
  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.count !== '0 || bus.tc !== 1'b0 || bus.cmp_match !== (s_cmp == 0)) begin
      failed++;
      $display("FAIL %s got count=%0d tc=%0b cmp=%0b expected count=0 tc=0 cmp=%0b",
               name, bus.count, bus.tc, bus.cmp_match, (s_cmp == 0));
    end
    s_en   = 0;
    s_load = 0;
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 0;
    m_pre = 0;
    m_tc  = 1'b0;
    drive_cycle();
  endtask

  initial begin
    rst = 1'b1;
    s_en = 0; s_dir = 1; s_sat = 0; s_load = 0; s_lv = 0;
    s_max = 255; s_presc = 0; s_cmp = 0;
    bus.en = 1'b0; bus.dir = 1'b1; bus.mode_sat = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.max_val = '1; bus.presc = '0; bus.cmp_val = '0;
    m_cnt = 0; m_pre = 0; m_tc = 1'b0;
    do_reset("reset_init");

    // Wrap at max=9, count up from 0.
    s_max = 9; s_dir = 1; s_sat = 0; s_presc = 0; s_en = 1; s_cmp = 0;
    step(10);
    check_now("wrap_up_tc", 0, 1'b1, 1'b1);
    step(1);
    check_now("wrap_up_after", 1, 1'b0, 1'b0);

    // Saturate at max=5.
    s_load = 1; s_lv = 0; s_max = 5; s_sat = 1; s_cmp = 5;
    step(1);
    s_load = 0;
    step(5);
    check_now("sat_arrive", 5, 1'b1, 1'b1);
    step(3);
    check_now("sat_hold", 5, 1'b0, 1'b1);

    // Down from 0, wrap then saturate.
    s_max = 9; s_sat = 0; s_load = 1; s_lv = 0; s_cmp = 9;
    step(1);
    s_load = 0; s_dir = 0;
    step(1);
    check_now("down_wrap", 9, 1'b1, 1'b1);
    s_load = 1; s_sat = 1;
    step(1);
    s_load = 0;
    step(1);
    check_now("down_sat", 0, 1'b0, 1'b0);

    // Prescaler /4 and freeze with en low.
    s_max = 200; s_dir = 1; s_sat = 0; s_presc = 3; s_load = 1; s_lv = 0; s_cmp = 3;
    step(1);
    s_load = 0;
    step(8);
    check_now("presc_div4", 2, 1'b0, 1'b0);
    s_en = 0;
    step(5);
    check_now("presc_frozen", 2, 1'b0, 1'b0);
    s_en = 1;
    step(3);
    check_now("presc_resume", 2, 1'b0, 1'b0);
    step(1);
    check_now("presc_tick", 3, 1'b0, 1'b1);

    // Load beyond the limit clamps; coincident tick discarded.
    s_max = 100; s_lv = 200; s_load = 1; s_presc = 0; s_cmp = 100;
    step(1);
    s_load = 0;
    check_now("load_clamp", 100, 1'b0, 1'b1);

    // max_val=0: every wrap-mode tick pulses tc.
    s_max = 0; s_lv = 0; s_load = 1; s_cmp = 0;
    step(1);
    s_load = 0;
    step(1);
    check_now("max0_tick1", 0, 1'b1, 1'b1);
    step(1);
    check_now("max0_tick2", 0, 1'b1, 1'b1);

    // Asynchronous reset mid-count.
    s_max = 100; s_lv = 7; s_load = 1; s_cmp = 7;
    step(1);
    s_load = 0; s_en = 0;
    do_reset("reset_async");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) begin
        case ($urandom_range(0, 3))
          0: s_max = 0;
          1: s_max = $urandom_range(1, 3);
          2: s_max = $urandom_range(4, 20);
          default: s_max = $urandom_range(0, 255);
        endcase
      end
      s_en    = ($urandom_range(0, 9) < 8) ? 1 : 0;
      s_dir   = $urandom_range(0, 1);
      if (i % 7 == 0) s_sat = $urandom_range(0, 1);
      s_load  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      s_lv    = $urandom_range(0, 255);
      s_presc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      s_cmp   = (s_max < 255) ? $urandom_range(0, s_max + 1) : $urandom_range(0, 255);
      step(1);
      if ($urandom_range(0, 149) == 0) do_reset("reset_random");
    end

    s_en = 0;
    s_load = 0;
    step(1);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
